// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/forwarding control: load-use bubbles, operand forwarding and data-memory wait sequencing.
// Define PIPE_STALL_CNT_EN to build the mem/load-use stall performance counters (tied to 0 otherwise).
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       drs,
    input  logic [4:0]       drt,
    input  logic             duse_rs,
    input  logic             duse_rt,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       erd,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic             mwmem,
    input  logic [4:0]       mrd,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             de_bubble,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             mem_err,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] tcnt;
    logic       mem_op;
    logic       req;
    logic       freeze;
    logic       lu;
    logic       stall;
    logic       bub;

    // Handshake: dmem_req is held from the first request cycle through the cycle dmem_ack
    // is seen high; the access completes on that ack cycle and the pipeline advances then.
    always_comb begin
        mem_op = mm2reg | mwmem;
        req    = 1'b0;
        freeze = 1'b0;
        case (state)
            IDLE: begin
                req    = mem_op;
                freeze = mem_op & ~dmem_ack;
            end
            WAIT: begin
                req    = 1'b1;
                freeze = ~dmem_ack;
            end
            ERR: begin
                req    = 1'b0;
                freeze = 1'b1;
            end
            default: begin
                req    = 1'b0;
                freeze = 1'b0;
            end
        endcase
    end

    assign lu = ewreg & em2reg & (erd != 5'd0) &
                ((duse_rs & (erd == drs)) | (duse_rt & (erd == drt)));

    // Freeze outranks the hazard, so a hazard held during a freeze costs one bubble afterwards.
    assign stall     = ~clr & freeze;
    assign bub       = ~clr & ~freeze & lu;
    assign pc_en     = ~stall & ~bub;
    assign fd_en     = ~stall & ~bub;
    assign de_en     = ~stall;
    assign em_en     = ~stall;
    assign mw_en     = ~stall;
    assign de_bubble = bub;
    assign dmem_req  = ~clr & req;
    assign mem_err   = ~clr & (state == ERR);
    assign dbg_state = state;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (ewreg && !em2reg && erd != 5'd0 && erd == src)
            return 2'b01;
        else if (mwreg && mm2reg && mrd != 5'd0 && mrd == src)
            return 2'b11;
        else if (mwreg && !mm2reg && mrd != 5'd0 && mrd == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign fwda = clr ? 2'b00 : fwd_sel(drs);
    assign fwdb = clr ? 2'b00 : fwd_sel(drt);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            tcnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && !dmem_ack) begin
                        state <= WAIT;
                        tcnt  <= 8'd1;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state <= IDLE;
                        tcnt  <= 8'd0;
                    end else if (tcnt == TIMEOUT_C) begin
                        state <= ERR;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                ERR: state <= ERR;
                default: begin
                    state <= IDLE;
                    tcnt  <= 8'd0;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] mem_cnt_q;
    logic [CNT_W-1:0] lu_cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            mem_cnt_q <= '0;
            lu_cnt_q  <= '0;
        end else begin
            if (freeze && !(&mem_cnt_q))
                mem_cnt_q <= mem_cnt_q + CNT_W'(1);
            if (lu && !freeze && !(&lu_cnt_q))
                lu_cnt_q <= lu_cnt_q + CNT_W'(1);
        end
    end

    assign mem_stall_cnt = clr ? '0 : mem_cnt_q;
    assign lu_stall_cnt  = clr ? '0 : lu_cnt_q;
`else
    assign mem_stall_cnt = '0;
    assign lu_stall_cnt  = '0;
`endif

endmodule
